// File: rtl/turn_signal_pkg.sv
// Shared definitions for the turn-signal controller: state encoding,
// default timing parameters and the per-side twinkle decode.
package turn_signal_pkg;

  localparam int DEF_HALF_PERIOD     = 25_000_000;
  localparam int DEF_COMFORT_FLASHES = 3;
  localparam int DEF_SYNC_STAGES     = 2;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_IDLE      = 3'd1,
    S_LEFT      = 3'd2,
    S_RIGHT     = 3'd3,
    S_LEFT_EXT  = 3'd4,
    S_RIGHT_EXT = 3'd5,
    S_HAZARD    = 3'd6
  } state_t;

  function automatic logic twinkles_left(input state_t s);
    return s inside {S_LEFT, S_LEFT_EXT, S_HAZARD};
  endfunction

  function automatic logic twinkles_right(input state_t s);
    return s inside {S_RIGHT, S_RIGHT_EXT, S_HAZARD};
  endfunction

endpackage

// File: rtl/blink_divider.sv
// Slow blink clock generator: toggles every HALF_PERIOD clk cycles and
// emits a one-cycle tick in the cycle the blink clock has just risen.
module blink_divider
  import turn_signal_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic blink_clk,
  output logic tick
);

  localparam int            CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          r_blink;
  logic          r_tick;

  // NOTE: non-blocking assignments so count, toggle and tick all sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_blink <= 1'b0;
      r_tick  <= 1'b0;
    end else if (!en || restart) begin
      r_count <= '0;
      r_blink <= 1'b0;
      r_tick  <= 1'b0;
    end else if (r_count == LAST) begin
      r_count <= '0;
      r_blink <= ~r_blink;
      r_tick  <= ~r_blink;
    end else begin
      r_count <= r_count + 1'b1;
      r_tick  <= 1'b0;
    end
  end

  assign blink_clk = r_blink;
  assign tick      = r_tick;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turns raw car-control levels into per-side stay/twinkle lamp commands,
// with comfort-blink extension after a turn request is released.
module turn_signal_ctrl
  import turn_signal_pkg::*;
#(
  parameter int HALF_PERIOD     = DEF_HALF_PERIOD,
  parameter int COMFORT_FLASHES = DEF_COMFORT_FLASHES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic power_on,
  input  logic turn_left,
  input  logic turn_right,
  input  logic hazard,
  input  logic brake,
  input  logic reverse,
  output logic blink_clk,
  output logic stay_left,
  output logic stay_right,
  output logic twinkle_left,
  output logic twinkle_right
);

  localparam int            EXT_MAX  = 2 * COMFORT_FLASHES;
  localparam int            EW       = $clog2(EXT_MAX + 1);
  localparam logic [EW-1:0] EXT_FULL = EW'(EXT_MAX);

  logic [5:0] w_raw;
  logic [5:0] w_sync;
  logic [5:0] r_sync [SYNC_STAGES];

  assign w_raw = {power_on, hazard, turn_left, turn_right, brake, reverse};

  // Every control level is asynchronous to clk, so each bit gets its own chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  logic w_pw, w_hz, w_br, w_rv, w_left_only, w_right_only;
  assign w_pw         = w_sync[5];
  assign w_hz         = w_sync[4];
  assign w_left_only  = w_sync[3] & ~w_sync[2];
  assign w_right_only = w_sync[2] & ~w_sync[3];
  assign w_br         = w_sync[1];
  assign w_rv         = w_sync[0];

  state_t        r_state, w_next;
  logic [EW-1:0] r_ext, w_ext_next, w_ext_inc;
  logic          w_tick, w_restart;
  logic          r_tw_l, r_tw_r, r_stay;

  blink_divider #(.HALF_PERIOD(HALF_PERIOD)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_pw),
    .restart   (w_restart),
    .blink_clk (blink_clk),
    .tick      (w_tick)
  );

  assign w_ext_inc = (r_ext == EXT_FULL) ? r_ext : r_ext + 1'b1;
  assign w_restart = (r_state == S_IDLE) && (w_next inside {S_LEFT, S_RIGHT, S_HAZARD});

  // NOTE: every output of this block is defaulted first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_ext_next = '0;
    if (r_state == S_OFF) begin
      if (w_pw) w_next = S_IDLE;
    end else if (!w_pw) begin
      w_next = S_OFF;
    end else if (w_hz) begin
      w_next = S_HAZARD;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_left_only)       w_next = S_LEFT;
          else if (w_right_only) w_next = S_RIGHT;
        end
        S_LEFT: begin
          if (w_right_only)      w_next = S_RIGHT;
          else if (!w_left_only) w_next = S_LEFT_EXT;
        end
        S_RIGHT: begin
          if (w_left_only)        w_next = S_LEFT;
          else if (!w_right_only) w_next = S_RIGHT_EXT;
        end
        S_LEFT_EXT, S_RIGHT_EXT: begin
          if (w_left_only)       w_next = S_LEFT;
          else if (w_right_only) w_next = S_RIGHT;
          else begin
            w_ext_next = w_tick ? w_ext_inc : r_ext;
            if (w_tick && w_ext_inc == EXT_FULL) w_next = S_IDLE;
          end
        end
        S_HAZARD: w_next = S_IDLE;
        default:  w_next = S_OFF;
      endcase
    end
  end

  // Twinkles are decoded from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_ext   <= '0;
      r_tw_l  <= 1'b0;
      r_tw_r  <= 1'b0;
      r_stay  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ext   <= w_ext_next;
      r_tw_l  <= twinkles_left(w_next);
      r_tw_r  <= twinkles_right(w_next);
      r_stay  <= w_pw & (w_br | w_rv);
    end
  end

  assign twinkle_left  = r_tw_l;
  assign twinkle_right = r_tw_r;
  assign stay_left     = r_stay;
  assign stay_right    = r_stay;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: stimulus table, hand-timed corner sequences,
// then random levels checked every cycle against a behavioural model.
module tb_turn_signal_ctrl;

  localparam int HP = 4;
  localparam int CF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic power_on = 0, turn_left = 0, turn_right = 0, hazard = 0, brake = 0, reverse = 0;
  logic blink_clk, stay_left, stay_right, twinkle_left, twinkle_right;

  int n_cmp = 0;
  int n_err = 0;

  turn_signal_ctrl #(.HALF_PERIOD(HP), .COMFORT_FLASHES(CF), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .power_on      (power_on),
    .turn_left     (turn_left),
    .turn_right    (turn_right),
    .hazard        (hazard),
    .brake         (brake),
    .reverse       (reverse),
    .blink_clk     (blink_clk),
    .stay_left     (stay_left),
    .stay_right    (stay_right),
    .twinkle_left  (twinkle_left),
    .twinkle_right (twinkle_right)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: lit side as a direction, extension as ticks still owed,
  // blink phase as a cycle count inside one full blink period.
  typedef struct {
    bit on;
    bit hz;
    int dir;
    int ext;
    int p;
    bit stay;
  } mdl_t;

  mdl_t       m;
  logic [5:0] m_s1, m_s2;

  function automatic mdl_t mdl_next(input mdl_t c, input logic [5:0] s);
    mdl_t n = c;
    bit   pw = s[5], hz = s[4], l = s[3], r = s[2];
    int   want = (l && !r) ? -1 : (r && !l) ? 1 : 0;
    bit   tk = (c.p == HP);
    bit   restart = 0;
    n.stay = pw && (s[1] || s[0]);
    if (!c.on) begin
      if (pw) n.on = 1;
    end else if (!pw) begin
      n.on = 0; n.hz = 0; n.dir = 0; n.ext = 0;
    end else if (hz) begin
      restart = !c.hz && c.dir == 0;
      n.hz = 1; n.dir = 0; n.ext = 0;
    end else if (c.hz) begin
      n.hz = 0;
    end else if (c.dir == 0) begin
      if (want != 0) begin n.dir = want; restart = 1; end
    end else if (want != 0) begin
      n.dir = want; n.ext = 0;
    end else if (c.ext == 0) begin
      n.ext = 2 * CF;
    end else if (tk) begin
      n.ext = c.ext - 1;
      if (n.ext == 0) n.dir = 0;
    end
    n.p = (!pw || restart) ? 0 : (c.p + 1) % (2 * HP);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '{default: 0};
      m_s1 <= '0;
      m_s2 <= '0;
    end else begin
      m    <= mdl_next(m, m_s2);
      m_s2 <= m_s1;
      m_s1 <= {power_on, hazard, turn_left, turn_right, brake, reverse};
    end
  end

  function automatic logic [4:0] mdl_out(input mdl_t c);
    return {c.on && (c.hz || c.dir < 0), c.on && (c.hz || c.dir > 0),
            c.stay, c.stay, c.p >= HP};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input string name);
    logic prev = blink_clk;
    bit   got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (blink_clk && !prev) got = 1;
      prev = blink_clk;
    end
    check(name, got, 1);
  endtask

  // Runs from a release aligned with a blink rise until twinkle_left drops.
  task automatic ext_measure(output int rises, output int edges);
    logic prev = blink_clk;
    rises = 0;
    edges = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      edges++;
      if (blink_clk && !prev) rises++;
      prev = blink_clk;
      if (!twinkle_left) break;
    end
  endtask

  typedef struct packed {
    logic pw, hz, l, r, br, rv;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int rises, edges, drops, hold;
    bit found;

    tbl[0]  = '{1, 0, 0, 0, 0, 0, 4'b0000};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 4'b0011};
    tbl[2]  = '{1, 0, 1, 1, 0, 0, 4'b0000};
    tbl[3]  = '{1, 0, 1, 0, 0, 0, 4'b1000};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 4'b0100};
    tbl[5]  = '{1, 1, 0, 0, 1, 0, 4'b1111};
    tbl[6]  = '{1, 1, 1, 0, 0, 0, 4'b1100};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 4'b0000};
    tbl[8]  = '{0, 1, 0, 0, 1, 0, 4'b0000};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, 4'b0100};
    tbl[10] = '{1, 0, 1, 1, 1, 0, 4'b0111};
    tbl[11] = '{1, 1, 0, 0, 0, 0, 4'b1100};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 4'b0000};

    cyc(2);
    check("reset_outputs",
          {twinkle_left, twinkle_right, stay_left, stay_right, blink_clk}, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      {power_on, hazard, turn_left, turn_right, brake, reverse} =
        {tbl[i].pw, tbl[i].hz, tbl[i].l, tbl[i].r, tbl[i].br, tbl[i].rv};
      cyc(6);
      check($sformatf("vec%0d", i),
            {twinkle_left, twinkle_right, stay_left, stay_right}, tbl[i].exp);
    end

    // Left turn from idle: lamp on the 3rd edge, phase restarted there.
    turn_left = 1;
    cyc(2);  check("left_edge2", twinkle_left, 0);
    cyc(1);  check("left_edge3", {twinkle_left, twinkle_right, blink_clk}, 3'b100);
    cyc(3);  check("blink_edge6", blink_clk, 0);
    cyc(1);  check("blink_edge7", blink_clk, 1);
    cyc(3);  check("blink_edge10", blink_clk, 1);
    cyc(1);  check("blink_edge11", blink_clk, 0);
    cyc(3);  check("blink_edge14", blink_clk, 0);
    cyc(1);  check("blink_edge15", {blink_clk, twinkle_right}, 2'b10);

    // Comfort extension: exactly 2*CF rises, drop on the edge after the last.
    turn_left = 0;
    ext_measure(rises, edges);
    check("ext_rises", rises, 2 * CF);
    check("ext_edges", edges, 33);

    // Re-assert after the 2nd counted tick: lamp holds, counter restarts.
    turn_left = 1;
    cyc(8);
    turn_left = 0;
    cyc(3);
    rises = 0;
    begin
      logic prev = blink_clk;
      for (int k = 0; k < 40 && rises < 2; k++) begin
        @(negedge clk);
        if (blink_clk && !prev) rises++;
        prev = blink_clk;
      end
    end
    check("reassert_rises", rises, 2);
    turn_left = 1;
    drops = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (!twinkle_left) drops++;
    end
    check("reassert_hold", drops, 0);
    wait_rise("reassert_align");
    turn_left = 0;
    ext_measure(rises, edges);
    check("reext_rises", rises, 2 * CF);
    check("reext_edges", edges, 33);

    // Direction switch swaps sides on one edge with no left extension.
    turn_left = 1;
    cyc(6);
    turn_left = 0; turn_right = 1;
    cyc(2);  check("switch_edge2", {twinkle_left, twinkle_right}, 2'b10);
    cyc(1);  check("switch_edge3", {twinkle_left, twinkle_right}, 2'b01);
    hazard = 1; turn_right = 0;
    cyc(4);
    hazard = 0;
    cyc(4);  check("hazard_to_idle", {twinkle_left, twinkle_right}, 2'b00);
    turn_left = 1; turn_right = 1;
    cyc(8);  check("conflict_idle", {twinkle_left, twinkle_right}, 2'b00);

    // Hazard overrides turn; brake still gives stay; hazard drop goes via idle.
    hazard = 1; brake = 1; turn_right = 0;
    cyc(3);  check("hazard_brake",
                   {twinkle_left, twinkle_right, stay_left, stay_right}, 4'b1111);
    hazard = 0;
    cyc(3);  check("hazard_drop_idle", {twinkle_left, twinkle_right}, 2'b00);
    cyc(1);  check("hazard_drop_left", {twinkle_left, twinkle_right}, 2'b10);

    // Power loss while in the right extension.
    brake = 0; turn_left = 0; turn_right = 1;
    cyc(5);  check("right_active", twinkle_right, 1);
    turn_right = 0;
    cyc(5);  check("right_ext_active", twinkle_right, 1);
    power_on = 0;
    cyc(2);  check("pwr_drop_edge2", twinkle_right, 1);
    cyc(1);  check("pwr_drop_edge3",
                   {twinkle_left, twinkle_right, stay_left, stay_right, blink_clk}, 0);
    cyc(10); check("pwr_off_held", {twinkle_left, twinkle_right, blink_clk}, 0);
    power_on = 1;
    cyc(5);  check("pwr_on_blink_lo", blink_clk, 0);
    cyc(1);  check("pwr_on_blink_hi",
                   {twinkle_left, twinkle_right, blink_clk}, 3'b001);

    // Asynchronous reset while the left lamp is lit and blink_clk is high.
    turn_left = 1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1);
      if (twinkle_left && blink_clk) found = 1;
    end
    check("reset_precond", found, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset",
             {twinkle_left, twinkle_right, stay_left, stay_right, blink_clk}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);  check("post_reset_idle", twinkle_left, 0);
    cyc(1);  check("post_reset_left", twinkle_left, 1);

    // Random levels against the behavioural model.
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        power_on   = ($urandom_range(0, 9) != 0);
        hazard     = ($urandom_range(0, 5) == 0);
        turn_left  = $urandom_range(0, 1);
        turn_right = ($urandom_range(0, 2) == 0);
        brake      = $urandom_range(0, 1);
        reverse    = ($urandom_range(0, 4) == 0);
        hold       = $urandom_range(1, 50);
      end
      hold--;
      cyc(1);
      check($sformatf("rand%0d", k),
            {twinkle_left, twinkle_right, stay_left, stay_right, blink_clk},
            mdl_out(m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
